// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary popcount sequencer.
package tnn_pkg;

  // Controller states; exported on the debug port of the top block.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ternary activation encoding.
  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;
  localparam logic [1:0] ACT_ZERO = 2'b00;

  // Smallest accumulator width that cannot overflow when every chunk
  // returns the maximum popcount value.
  function automatic int min_acc_w(input int n_chunks, input int pc_w);
    return $clog2(n_chunks * ((1 << pc_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/ternary_threshold_cmp.sv
// Combinational ternary thresholding of a signed pos-neg difference.
module ternary_threshold_cmp
  import tnn_pkg::*;
#(
  parameter int THR_W = 6
) (
  input  logic signed [THR_W-1:0] diff,
  input  logic signed [THR_W-1:0] thr_hi,
  input  logic signed [THR_W-1:0] thr_lo,
  output logic        [1:0]       act
);

  // The upper test is evaluated first so it wins when thr_lo > thr_hi.
  always_comb begin
    act = ACT_ZERO;
    if (diff > thr_hi) begin
      act = ACT_POS;
    end else if (diff < thr_lo) begin
      act = ACT_NEG;
    end
  end

endmodule

// File: rtl/ternary_popcount_sequencer.sv
// Time-multiplexes one external popcount unit over the positive and then
// the negative weight mask of a ternary neuron, one chunk per cycle, and
// thresholds pos-neg into a ternary activation.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; in_valid is ignored otherwise. out_valid
// stays high with diff/act frozen until out_ready is seen high.
module ternary_popcount_sequencer
  import tnn_pkg::*;
#(
  parameter int N_CHUNKS = 4,
  parameter int CHUNK_W  = 7,
  parameter int PC_W     = 3,
  parameter int ACC_W    = min_acc_w(N_CHUNKS, PC_W),
  parameter int THR_W    = ACC_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CHUNKS*CHUNK_W-1:0]  pos_mask,
  input  logic [N_CHUNKS*CHUNK_W-1:0]  neg_mask,
  input  logic signed [THR_W-1:0]      thr_hi,
  input  logic signed [THR_W-1:0]      thr_lo,
  output logic [CHUNK_W-1:0]           pc_in,
  input  logic [PC_W-1:0]              pc_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   act,
  output logic signed [THR_W-1:0]      diff,
  output state_t                       dbg_state
);

  localparam int MASK_W = N_CHUNKS * CHUNK_W;
  localparam int IDX_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [MASK_W-1:0]        pos_q;
  logic [MASK_W-1:0]        neg_q;
  logic signed [THR_W-1:0]  thr_hi_q;
  logic signed [THR_W-1:0]  thr_lo_q;
  logic [ACC_W-1:0]         pos_acc;
  logic [ACC_W-1:0]         neg_acc;

  logic [ACC_W-1:0]         pc_ext;
  logic signed [THR_W-1:0]  diff_c;
  logic [1:0]               act_c;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // Popcount results are unsigned; the accumulator width guarantees no wrap.
  assign pc_ext = ACC_W'(pc_out);

  // Both accumulators are non-negative, so zero-extend before subtracting.
  assign diff_c = $signed(THR_W'(pos_acc)) - $signed(THR_W'(neg_acc));

  ternary_threshold_cmp #(
    .THR_W (THR_W)
  ) u_cmp (
    .diff   (diff_c),
    .thr_hi (thr_hi_q),
    .thr_lo (thr_lo_q),
    .act    (act_c)
  );

  // Slice presented to the popcount unit; zero whenever no chunk is walked.
  always_comb begin
    pc_in = '0;
    case (state)
      POS:     pc_in = pos_q[CHUNK_W*int'(idx) +: CHUNK_W];
      NEG:     pc_in = neg_q[CHUNK_W*int'(idx) +: CHUNK_W];
      default: pc_in = '0;
    endcase
  end

  // Controller: capture request, walk pos then neg chunks, then hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pos_q     <= '0;
      neg_q     <= '0;
      thr_hi_q  <= '0;
      thr_lo_q  <= '0;
      pos_acc   <= '0;
      neg_acc   <= '0;
      out_valid <= 1'b0;
      act       <= ACT_ZERO;
      diff      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pos_q    <= pos_mask;
            neg_q    <= neg_mask;
            thr_hi_q <= thr_hi;
            thr_lo_q <= thr_lo;
            pos_acc  <= '0;
            neg_acc  <= '0;
            idx      <= '0;
            state    <= POS;
          end
        end
        POS: begin
          pos_acc <= pos_acc + pc_ext;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= NEG;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        NEG: begin
          neg_acc <= neg_acc + pc_ext;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle registers the result from settled accumulators.
          if (!out_valid) begin
            out_valid <= 1'b1;
            diff      <= diff_c;
            act       <= act_c;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_popcount_sequencer.sv
// Randomized self-checking bench for ternary_popcount_sequencer.
module tb_ternary_popcount_sequencer;
  import tnn_pkg::*;

  localparam int N_CHUNKS = 4;
  localparam int CHUNK_W  = 7;
  localparam int PC_W     = 3;
  localparam int THR_W    = 6;
  localparam int MASK_W   = N_CHUNKS * CHUNK_W;
  localparam int RES_W    = THR_W + 2;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [MASK_W-1:0]        pos_mask;
  logic [MASK_W-1:0]        neg_mask;
  logic signed [THR_W-1:0]  thr_hi;
  logic signed [THR_W-1:0]  thr_lo;
  logic [CHUNK_W-1:0]       pc_in;
  logic [PC_W-1:0]          pc_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               act;
  logic signed [THR_W-1:0]  diff;
  state_t                   dbg_state;

  int n_checks;
  int n_errors;
  int pc_mode;
  logic [RES_W-1:0] exp_q[$];

  ternary_popcount_sequencer #(
    .N_CHUNKS (N_CHUNKS),
    .CHUNK_W  (CHUNK_W),
    .PC_W     (PC_W),
    .ACC_W    (5),
    .THR_W    (THR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pos_mask  (pos_mask),
    .neg_mask  (neg_mask),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .act       (act),
    .diff      (diff),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Popcount stand-ins: 0 exact, 1 constant 2, 2 a deliberately wrong count.
  function automatic logic [PC_W-1:0] pc_model(input logic [CHUNK_W-1:0] x, input int mode);
    int c;
    c = $countones(x);
    case (mode)
      1:       return 3'd2;
      2:       return PC_W'((c + 3 * int'(x[0]) + int'(x[6])) % 8);
      default: return PC_W'(c);
    endcase
  endfunction

  always_comb pc_out = pc_model(pc_in, pc_mode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: sum per-chunk counts, subtract, threshold with signed ints.
  function automatic logic [RES_W-1:0] ref_result(input logic [MASK_W-1:0] pm,
                                                  input logic [MASK_W-1:0] nm,
                                                  input logic [THR_W-1:0] hi,
                                                  input logic [THR_W-1:0] lo);
    int p, n, d, hi_i, lo_i;
    logic [1:0] a;
    logic [THR_W-1:0] d_bits;
    p = 0;
    n = 0;
    for (int k = 0; k < N_CHUNKS; k++) begin
      p += int'(pc_model(pm[k*CHUNK_W +: CHUNK_W], pc_mode));
      n += int'(pc_model(nm[k*CHUNK_W +: CHUNK_W], pc_mode));
    end
    d    = p - n;
    hi_i = int'($signed(hi));
    lo_i = int'($signed(lo));
    if (d > hi_i)      a = 2'b01;
    else if (d < lo_i) a = 2'b11;
    else               a = 2'b00;
    d_bits = d[THR_W-1:0];
    return {a, d_bits};
  endfunction

  // Present a request one negedge ahead and clock it in.
  task automatic accept_req(input logic [MASK_W-1:0] pm, input logic [MASK_W-1:0] nm,
                            input logic [THR_W-1:0] hi, input logic [THR_W-1:0] lo);
    @(negedge clk);
    in_valid = 1'b1;
    pos_mask = pm;
    neg_mask = nm;
    thr_hi   = hi;
    thr_lo   = lo;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pos_mask = MASK_W'({$urandom, $urandom});
    neg_mask = MASK_W'({$urandom, $urandom});
    thr_hi   = THR_W'($urandom);
    thr_lo   = THR_W'($urandom);
  endtask

  // Full request: walk chunks, check latency and result, stall, handshake.
  task automatic run_req(input logic [MASK_W-1:0] pm, input logic [MASK_W-1:0] nm,
                         input logic [THR_W-1:0] hi, input logic [THR_W-1:0] lo,
                         input int hold);
    logic [RES_W-1:0] exp_r;
    exp_q.push_back(ref_result(pm, nm, hi, lo));
    accept_req(pm, nm, hi, lo);
    for (int k = 0; k < N_CHUNKS; k++) begin
      check("pc_in_pos", 32'(pc_in), 32'(pm[k*CHUNK_W +: CHUNK_W]));
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < N_CHUNKS; k++) begin
      check("pc_in_neg", 32'(pc_in), 32'(nm[k*CHUNK_W +: CHUNK_W]));
      check("out_valid_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check("pc_in_done", 32'(pc_in), 32'd0);
    check("out_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("out_valid_latency", 32'(out_valid), 32'd1);
    exp_r = exp_q.pop_front();
    check("result", 32'({act, diff}), 32'(exp_r));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_result", 32'({act, diff}), 32'(exp_r));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  // Reset asserted during NEG chunk 2 must clear everything immediately.
  task automatic abort_req(input logic [MASK_W-1:0] pm, input logic [MASK_W-1:0] nm);
    accept_req(pm, nm, 6'd0, 6'd0);
    repeat (N_CHUNKS + 2) @(posedge clk);
    #1;
    check("abort_pc_in", 32'(pc_in), 32'(nm[2*CHUNK_W +: CHUNK_W]));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'({act, diff}), 32'd0);
    check("abort_pc_in_zero", 32'(pc_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Stimulus and report
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    pc_mode   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pos_mask  = '0;
    neg_mask  = '0;
    thr_hi    = '0;
    thr_lo    = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'({act, diff}), 32'd0);
    check("rst_pc_in", 32'(pc_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pc_mode = 0;
    run_req(28'hFFFFFFF, 28'h0, 6'd0, 6'd0, 0);
    run_req(28'h0000007, 28'h7F00000, 6'd2, 6'h3E, 1);
    pc_mode = 1;
    run_req(MASK_W'({$urandom, $urandom}), MASK_W'({$urandom, $urandom}), 6'd0, 6'd0, 5);
    pc_mode = 0;
    run_req(28'h0, 28'h0, 6'h3B, 6'd5, 0);
    abort_req(28'hFFFFFFF, 28'hFFFFFFF);
    run_req(28'h00000FF, 28'h0000001, 6'd3, 6'h3D, 0);

    for (int i = 0; i < 24; i++) begin
      pc_mode = int'($urandom_range(0, 2));
      run_req(MASK_W'({$urandom, $urandom}), MASK_W'({$urandom, $urandom}),
              THR_W'($urandom_range(0, 63)), THR_W'($urandom_range(0, 63)),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
